// File: rtl/cache_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a shared L2 port.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed D priority for alternating grant.
module cache_arbiter #(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, TURN} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [31:0]       addr;
    logic [s_line-1:0] wdata;
  } mem_req_t;

  state_t   state, state_nxt;
  mem_req_t mreq;
  logic     d_req, grant_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant; // 0 = I, 1 = D

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b0;
    else if (state == IDLE && (d_req || i_read))
      last_grant <= grant_d;
  end

  // on contention, grant whichever port was not served last
  assign grant_d = d_req && (!i_read || !last_grant);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mreq      = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state)
      IDLE: begin
        if (grant_d)     state_nxt = SERVE_D;
        else if (i_read) state_nxt = SERVE_I;
      end
      SERVE_I: begin
        mreq.rd   = i_read;
        mreq.addr = i_address;
        i_resp    = mem_resp;
        i_rdata   = mem_rdata;
        if (mem_resp) state_nxt = TURN;
      end
      SERVE_D: begin
        mreq.rd    = d_read;
        mreq.wr    = d_write;
        mreq.addr  = d_address;
        mreq.wdata = d_wdata;
        d_resp     = mem_resp;
        d_rdata    = mem_rdata;
        if (mem_resp) state_nxt = TURN;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_read    = mreq.rd;
  assign mem_write   = mreq.wr;
  assign mem_address = mreq.addr;
  assign mem_wdata   = mreq.wdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed, table-driven bench for cache_arbiter; each row is one clock cycle
// of inputs plus the outputs expected in that cycle, before the next edge.
module tb_cache_arbiter;
  localparam int L = 256;
  localparam logic [L-1:0] RD  = {32{8'hA5}};
  localparam logic [L-1:0] WD  = {16{16'h1234}};
  localparam logic [31:0]  IA  = 32'h0000_0040;
  localparam logic [31:0]  DA  = 32'h0000_1000;
  localparam logic [31:0]  DA2 = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst, i_read, d_read, d_write, mem_resp;
  logic [31:0] i_address, d_address;
  logic [L-1:0] d_wdata, mem_rdata;
  logic [L-1:0] i_rdata, d_rdata, mem_wdata;
  logic i_resp, d_resp, mem_read, mem_write;
  logic [31:0] mem_address;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.s_line(L)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // in = {rst, i_read, d_read, d_write, mem_resp}
  // e  = {mem_wdata==WD, i_resp, d_resp, i_rdata==RD, d_rdata==RD}
  typedef struct {
    string       nm;
    logic [4:0]  in;
    logic [31:0] ia, da;
    logic [1:0]  e_mrw;
    logic [31:0] e_ma;
    logic [4:0]  e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(string nm, logic [4:0] in, logic [31:0] ia, logic [31:0] da,
                             logic [1:0] e_mrw, logic [31:0] e_ma, logic [4:0] e);
    vec_t t;
    t.nm = nm; t.in = in; t.ia = ia; t.da = da;
    t.e_mrw = e_mrw; t.e_ma = e_ma; t.e = e;
    return t;
  endfunction

  task automatic chk(string nm, logic [L-1:0] got, logic [L-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic apply(vec_t t, int idx);
    @(negedge clk);
    {rst, i_read, d_read, d_write, mem_resp} = t.in;
    i_address = t.ia;
    d_address = t.da;
    d_wdata   = WD;
    mem_rdata = RD;
    #1;
    chk($sformatf("%0d:%s mem_ctl", idx, t.nm), L'({mem_read, mem_write, mem_address}),
        L'({t.e_mrw, t.e_ma}));
    chk($sformatf("%0d:%s mem_wdata", idx, t.nm), mem_wdata, t.e[4] ? WD : '0);
    chk($sformatf("%0d:%s resp", idx, t.nm), L'({i_resp, d_resp}), L'(t.e[3:2]));
    chk($sformatf("%0d:%s i_rdata", idx, t.nm), i_rdata, t.e[1] ? RD : '0);
    chk($sformatf("%0d:%s d_rdata", idx, t.nm), d_rdata, t.e[0] ? RD : '0);
  endtask

  initial begin
    bit rr;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    {rst, i_read, d_read, d_write, mem_resp} = 5'b10000;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    // reset state, then lone I read with resp 5 cycles in
    tbl.push_back(v("rst_state", 5'b00000, IA, DA, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("i_idle",    5'b01000, IA, DA, 2'b00, 32'h0, 5'b00000));
    for (int c = 1; c <= 4; c++)
      tbl.push_back(v("i_serve", 5'b01000, IA, DA, 2'b10, IA, 5'b00010));
    tbl.push_back(v("i_resp",    5'b01001, IA, DA, 2'b10, IA, 5'b01010));
    tbl.push_back(v("i_turn_stray", 5'b00001, IA, DA, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("idle_stray", 5'b00001, IA, DA, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("idle_stay", 5'b00000, IA, DA, 2'b00, 32'h0, 5'b00000));

    // lone D write, resp 3 cycles in
    tbl.push_back(v("dw_idle",  5'b00010, IA, DA, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("dw_serve", 5'b00010, IA, DA, 2'b01, DA, 5'b10001));
    tbl.push_back(v("dw_serve", 5'b00010, IA, DA, 2'b01, DA, 5'b10001));
    tbl.push_back(v("dw_resp",  5'b00011, IA, DA, 2'b01, DA, 5'b10101));
    tbl.push_back(v("dw_turn",  5'b00000, IA, DA, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("dw_idle2", 5'b00000, IA, DA, 2'b00, 32'h0, 5'b00000));

    // simultaneous I and D reads, latency 2: D first, then I
    tbl.push_back(v("sim_rst",   5'b10000, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("sim_idle",  5'b01100, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("sim_sd",    5'b01100, IA, DA2, 2'b10, DA2, 5'b10001));
    tbl.push_back(v("sim_sd_r",  5'b01101, IA, DA2, 2'b10, DA2, 5'b10101));
    tbl.push_back(v("sim_turn",  5'b01000, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("sim_idle2", 5'b01000, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("sim_si",    5'b01000, IA, DA2, 2'b10, IA, 5'b00010));
    tbl.push_back(v("sim_si_r",  5'b01001, IA, DA2, 2'b10, IA, 5'b01010));
    tbl.push_back(v("sim_turn2", 5'b00000, IA, DA2, 2'b00, 32'h0, 5'b00000));

    // both held for 4 transactions: D,I,D,I with round robin, D every time otherwise
    tbl.push_back(v("held_rst",  5'b10000, IA, DA2, 2'b00, 32'h0, 5'b00000));
    for (int t = 0; t < 4; t++) begin
      bit gd;
      gd = rr ? (t % 2 == 0) : 1'b1;
      tbl.push_back(v("held_idle", 5'b01100, IA, DA2, 2'b00, 32'h0, 5'b00000));
      if (gd) begin
        tbl.push_back(v("held_sd",   5'b01100, IA, DA2, 2'b10, DA2, 5'b10001));
        tbl.push_back(v("held_sd_r", 5'b01101, IA, DA2, 2'b10, DA2, 5'b10101));
      end else begin
        tbl.push_back(v("held_si",   5'b01100, IA, DA2, 2'b10, IA, 5'b00010));
        tbl.push_back(v("held_si_r", 5'b01101, IA, DA2, 2'b10, IA, 5'b01010));
      end
      tbl.push_back(v("held_turn", 5'b01100, IA, DA2, 2'b00, 32'h0, 5'b00000));
    end

    // reset two cycles into SERVE_D, then a late mem_resp
    tbl.push_back(v("mrst_drop", 5'b00000, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("mrst_idle", 5'b00100, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("mrst_sd1",  5'b00100, IA, DA2, 2'b10, DA2, 5'b10001));
    tbl.push_back(v("mrst_sd2",  5'b10100, IA, DA2, 2'b10, DA2, 5'b10001));
    tbl.push_back(v("mrst_after", 5'b00000, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("mrst_late", 5'b00001, IA, DA2, 2'b00, 32'h0, 5'b00000));
    tbl.push_back(v("mrst_idle2", 5'b00000, IA, DA2, 2'b00, 32'h0, 5'b00000));

    foreach (tbl[i]) apply(tbl[i], i);

    // strobe dropped mid-serve: arbiter still waits for mem_resp
    apply(v("drop_idle", 5'b00100, IA, DA, 2'b00, 32'h0, 5'b00000), 100);
    apply(v("drop_sd",   5'b00100, IA, DA, 2'b10, DA, 5'b10001), 101);
    apply(v("drop_low1", 5'b00000, IA, DA, 2'b00, DA, 5'b10001), 102);
    apply(v("drop_low2", 5'b00000, IA, DA, 2'b00, DA, 5'b10001), 103);
    apply(v("drop_resp", 5'b00001, IA, DA, 2'b00, DA, 5'b10101), 104);
    apply(v("drop_turn", 5'b00000, IA, DA, 2'b00, 32'h0, 5'b00000), 105);

    // illegal read+write together is forwarded unchanged
    apply(v("rw_idle", 5'b00110, IA, DA, 2'b00, 32'h0, 5'b00000), 110);
    apply(v("rw_sd",   5'b00110, IA, DA, 2'b11, DA, 5'b10001), 111);
    apply(v("rw_resp", 5'b00111, IA, DA, 2'b11, DA, 5'b10101), 112);
    apply(v("rw_turn", 5'b00000, IA, DA, 2'b00, 32'h0, 5'b00000), 113);
    apply(v("rw_idle2", 5'b00000, IA, DA, 2'b00, 32'h0, 5'b00000), 114);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
